outlier_column_detector: RTL and testbench
==========================================

Name: outlier_column_detector

Overview:
- Sits directly upstream of the scatter stage and produces its ind_table column-classification vector.
- Streams one activation tile of IN_DEPTH beats; each beat carries IN_PARALLELISM rows of IN_SIZE columns.
- Tracks the per-column absolute maximum across the whole tile and compares it against a runtime threshold.
- Emits a one-bit large/small flag per column, plus a large-column count, on a valid/ready handshake.

Parameters:
- IN_WIDTH, 16: element width, sign-magnitude float (FP16). Magnitude is bits [IN_WIDTH-2:0].
- IN_SIZE, 4: columns per row.
- IN_PARALLELISM, 1: rows per beat.
- IN_DEPTH, 4: beats per tile (>=1).
- OUT_LARGE_COLUMNS, 2: expected number of large columns, used for the mismatch flag.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- data_in  in  IN_WIDTH x (IN_SIZE*IN_PARALLELISM)  flattened beat; element [r*IN_SIZE+c] is row r, column c.
- data_in_valid  in  1  beat valid.
- data_in_ready  out  1  beat accepted when valid && ready.
- threshold  in  IN_WIDTH-1  magnitude threshold; sampled on the first beat of each tile.
- ind_table  out  1 x IN_SIZE  1 = large column, 0 = small column.
- large_count  out  $clog2(IN_SIZE+1)  number of ones in ind_table.
- count_mismatch  out  1  large_count != OUT_LARGE_COLUMNS.
- ind_valid  out  1  result valid.
- ind_ready  in  1  result consumed when valid && ready.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: state=ACCUM, beat_cnt=0, col_max[*]=0, thr_q=0, ind_table=0, large_count=0, count_mismatch=0, ind_valid=0. data_in_ready=0 while rst is high.
- FSM has two states.
- ACCUM:
  - data_in_ready=1, ind_valid=0.
  - On each accepted beat: beat_mag[c] = max over rows r of data_in[r*IN_SIZE+c][IN_WIDTH-2:0], compared as unsigned.
  - If beat_cnt==0: col_max[c] <= beat_mag[c] (overwrite, no clear cycle needed) and thr_q <= threshold.
  - Otherwise: col_max[c] <= max(col_max[c], beat_mag[c]).
  - beat_cnt increments per accepted beat. On the accepted beat with beat_cnt==IN_DEPTH-1:
    - Compute the final max, including the current beat, combinationally.
    - ind_table[c] <= final_max[c] > thr_q (strict). When IN_DEPTH==1, compare against the live threshold instead of thr_q.
    - Register large_count and count_mismatch.
    - beat_cnt <= 0; go to HOLD.
- HOLD:
  - ind_valid=1, data_in_ready=0.
  - ind_table, large_count and count_mismatch stay stable until the handshake.
  - On ind_valid && ind_ready: go to ACCUM. The next tile may be accepted the following cycle.
- Latency: ind_valid rises the cycle after the last beat is accepted. Throughput is IN_DEPTH+1 cycles per tile with ind_ready held high.
- Beats with data_in_valid=0 do not advance beat_cnt; gaps are allowed anywhere.
- Magnitude rules:
  - Inf and NaN compare above any finite threshold and are flagged large.
  - +0 and -0 both have magnitude 0.
  - Equality with the threshold yields small.
- threshold changes mid-tile are ignored; only the first-beat sample (thr_q) is used.
- rst mid-tile or in HOLD aborts: the partial tile is discarded, outputs return to reset values the next cycle, and ind_valid drops.
- count_mismatch is advisory only. It does not stall and the result is still presented.

Decomposition:
- Shared package outlier_pkg:
  - state enum {ACCUM, HOLD}.
  - Function mag(x) returning x[IN_WIDTH-2:0].
  - localparam CNT_W = $clog2(IN_SIZE+1).
  - localparam BEAT_W = $clog2(IN_DEPTH) (minimum 1).
- Sub-module column_absmax: combinational per-beat reduction (sign strip plus max over IN_PARALLELISM rows per column), producing beat_mag[IN_SIZE].
- Top level holds the FSM, beat counter, accumulators, comparators and popcount.

Test Plan:
- Basic tile: IN_SIZE=4, IN_PARALLELISM=1, IN_DEPTH=4, threshold=0x4000 (2.0). Four beats with col1=0x4400 (4.0) in beat 2 and col3=0xC500 (-5.0) in beat 0, all else 0x3C00 (1.0) → one cycle after beat 3: ind_table=4'b1010, large_count=2, count_mismatch=0, ind_valid=1.
- Equality and signs: col0=0x4000 exactly, col2=0x8000 (-0), threshold=0x4000 → ind_table[0]=0, ind_table[2]=0. Col with 0x7E00 (NaN) → 1.
- Backpressure: hold ind_ready=0 for 5 cycles after ind_valid → data_in_ready=0 and ind_table stable throughout. Raise ind_ready → next cycle state=ACCUM, data_in_ready=1, and a back-to-back second tile yields an independent result (no carry-over of col_max).
- Threshold sampling and gaps: change threshold from 0x4000 to 0x3000 after beat 0, insert valid=0 bubbles between beats → result uses 0x4000 and beat count is unaffected.
- Mismatch: all four columns 0x4800 with threshold 0x4000 → ind_table=4'b1111, large_count=4, count_mismatch=1.
- Reset mid-tile: assert rst after beat 2 for one cycle, then send a full new tile → no ind_valid from the aborted tile; result reflects the new tile only.

Source files
------------

// File: rtl/outlier_pkg.sv
// Shared types and default geometry for the outlier column detector.
// The top-level parameters default to the values defined here.
package outlier_pkg;

    localparam int DEF_IN_WIDTH          = 16;
    localparam int DEF_IN_SIZE           = 4;
    localparam int DEF_IN_PARALLELISM    = 1;
    localparam int DEF_IN_DEPTH          = 4;
    localparam int DEF_OUT_LARGE_COLUMNS = 2;

    localparam int CNT_W  = $clog2(DEF_IN_SIZE + 1);
    localparam int BEAT_W = (DEF_IN_DEPTH > 1) ? $clog2(DEF_IN_DEPTH) : 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Sign-magnitude element: dropping the sign bit gives an unsigned magnitude
    // whose ordering matches FP16 ordering, with Inf/NaN at the top.
    function automatic logic [DEF_IN_WIDTH-2:0] mag(input logic [DEF_IN_WIDTH-1:0] x);
        return x[DEF_IN_WIDTH-2:0];
    endfunction

endpackage

// File: rtl/outlier_column_detector_column_absmax.sv
// Combinational per-beat reduction: sign strip, then max over all rows of each column.
module column_absmax
    import outlier_pkg::*;
#(
    parameter int IN_WIDTH       = DEF_IN_WIDTH,
    parameter int IN_SIZE        = DEF_IN_SIZE,
    parameter int IN_PARALLELISM = DEF_IN_PARALLELISM
) (
    input  logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0] data_in,
    output logic [IN_WIDTH-2:0]                        beat_mag [IN_SIZE]
);

    logic [IN_WIDTH-2:0] m;

    always_comb begin
        m = '0;
        for (int c = 0; c < IN_SIZE; c++) begin
            beat_mag[c] = '0;
            for (int r = 0; r < IN_PARALLELISM; r++) begin
                m = mag(data_in[(r*IN_SIZE+c)*IN_WIDTH +: IN_WIDTH]);
                if (m > beat_mag[c]) begin
                    beat_mag[c] = m;
                end
            end
        end
    end

endmodule

// File: rtl/outlier_column_detector.sv
// Accumulates per-column magnitude maxima over a tile and flags columns above
// a threshold sampled on the tile's first beat.
//   state | meaning
//   ACCUM | accepting beats, updating col_max
//   HOLD  | result presented on ind_*, waiting for ind_ready
module outlier_column_detector
    import outlier_pkg::*;
#(
    parameter int IN_WIDTH          = DEF_IN_WIDTH,
    parameter int IN_SIZE           = DEF_IN_SIZE,
    parameter int IN_PARALLELISM    = DEF_IN_PARALLELISM,
    parameter int IN_DEPTH          = DEF_IN_DEPTH,
    parameter int OUT_LARGE_COLUMNS = DEF_OUT_LARGE_COLUMNS
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0] data_in,
    input  logic                                       data_in_valid,
    output logic                                       data_in_ready,
    input  logic [IN_WIDTH-2:0]                        threshold,
    output logic [IN_SIZE-1:0]                         ind_table,
    output logic [$clog2(IN_SIZE+1)-1:0]               large_count,
    output logic                                       count_mismatch,
    output logic                                       ind_valid,
    input  logic                                       ind_ready
);

    localparam int CW = $clog2(IN_SIZE + 1);
    localparam int BW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int MW = IN_WIDTH - 1;

    state_t          state;
    state_t          state_nx;
    logic [BW-1:0]   beat_cnt;
    logic [MW-1:0]   col_max   [IN_SIZE];
    logic [MW-1:0]   beat_mag  [IN_SIZE];
    logic [MW-1:0]   final_max [IN_SIZE];
    logic [MW-1:0]   thr_q;
    logic [MW-1:0]   thr_use;
    logic [IN_SIZE-1:0] table_nx;
    logic [CW-1:0]   count_nx;
    logic            accept;
    logic            first_beat;
    logic            last_beat;

    column_absmax #(
        .IN_WIDTH       (IN_WIDTH),
        .IN_SIZE        (IN_SIZE),
        .IN_PARALLELISM (IN_PARALLELISM)
    ) u_column_absmax (
        .data_in  (data_in),
        .beat_mag (beat_mag)
    );

    assign accept     = data_in_valid && data_in_ready;
    assign first_beat = (beat_cnt == '0);
    assign last_beat  = accept && (beat_cnt == BW'(IN_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACCUM:   if (last_beat) state_nx = HOLD;
            HOLD:    if (ind_ready) state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    always_comb begin
        data_in_ready = (state == ACCUM) && !rst;
        ind_valid     = (state == HOLD);
    end

    // A single-beat tile never gets a registered threshold in time, so it uses the live one.
    always_comb begin
        thr_use  = (IN_DEPTH == 1) ? threshold : thr_q;
        count_nx = '0;
        for (int c = 0; c < IN_SIZE; c++) begin
            final_max[c] = (first_beat || (beat_mag[c] > col_max[c])) ? beat_mag[c] : col_max[c];
            table_nx[c]  = (final_max[c] > thr_use);
            count_nx     = count_nx + CW'(table_nx[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt       <= '0;
            thr_q          <= '0;
            ind_table      <= '0;
            large_count    <= '0;
            count_mismatch <= 1'b0;
            for (int c = 0; c < IN_SIZE; c++) begin
                col_max[c] <= '0;
            end
        end else if (accept) begin
            if (first_beat) begin
                thr_q <= threshold;
            end
            for (int c = 0; c < IN_SIZE; c++) begin
                col_max[c] <= final_max[c];
            end
            if (last_beat) begin
                beat_cnt       <= '0;
                ind_table      <= table_nx;
                large_count    <= count_nx;
                count_mismatch <= (count_nx != CW'(OUT_LARGE_COLUMNS));
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_outlier_column_detector.sv
// Self-checking bench: directed tiles plus randomized tiles against a
// column-max reference model.
module tb_outlier_column_detector;

    localparam int W     = 16;
    localparam int SIZE  = 4;
    localparam int PAR   = 1;
    localparam int DEPTH = 4;
    localparam int NLC   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [W*SIZE*PAR-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic [W-2:0]          threshold;
    logic [SIZE-1:0]       ind_table;
    logic [2:0]            large_count;
    logic                  count_mismatch;
    logic                  ind_valid;
    logic                  ind_ready;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] cur [DEPTH][SIZE];
    logic [14:0] thr_r;

    outlier_column_detector #(
        .IN_WIDTH          (W),
        .IN_SIZE           (SIZE),
        .IN_PARALLELISM    (PAR),
        .IN_DEPTH          (DEPTH),
        .OUT_LARGE_COLUMNS (NLC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .threshold      (threshold),
        .ind_table      (ind_table),
        .large_count    (large_count),
        .count_mismatch (count_mismatch),
        .ind_valid      (ind_valid),
        .ind_ready      (ind_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a column is large when the largest |x| seen anywhere in that
    // column of the tile exceeds the first-beat threshold.
    function automatic logic [SIZE-1:0] model_table(input logic [14:0] thr);
        logic [SIZE-1:0] t;
        int unsigned mx;
        int unsigned v;
        t = '0;
        for (int c = 0; c < SIZE; c++) begin
            mx = 0;
            for (int b = 0; b < DEPTH; b++) begin
                v = int'(cur[b][c] & 16'h7FFF);
                if (v > mx) mx = v;
            end
            t[c] = (mx > int'(thr));
        end
        return t;
    endfunction

    function automatic logic [15:0] rnd_elem();
        logic [15:0] s;
        s = $urandom_range(0, 1) ? 16'h8000 : 16'h0000;
        case ($urandom_range(0, 7))
            0:       return s | 16'h7C00;
            1:       return s | 16'h7E00 | 16'($urandom_range(0, 255));
            2:       return s;
            3:       return s | {1'b0, thr_r};
            4:       return s | {1'b0, thr_r + 15'd1};
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic fill(input logic [15:0] v);
        for (int b = 0; b < DEPTH; b++)
            for (int c = 0; c < SIZE; c++)
                cur[b][c] = v;
    endtask

    task automatic send_beats(input int n, input logic [14:0] thr_first,
                              input logic [14:0] thr_later, input int gap_pct);
        int waits;
        for (int b = 0; b < n; b++) begin
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(0, 99) < gap_pct) begin
                    @(negedge clk);
                    data_in_valid = 1'b0;
                    data_in       = '1;
                    threshold     = 15'($urandom);
                end
            end
            @(negedge clk);
            for (int c = 0; c < SIZE; c++) data_in[c*W +: W] = cur[b][c];
            threshold     = (b == 0) ? thr_first : thr_later;
            data_in_valid = 1'b1;
            waits = 0;
            while (!data_in_ready && waits < 20) begin
                @(negedge clk);
                waits++;
            end
            if (waits == 20) chk("beat_accept_timeout", 0, 1);
            @(posedge clk);
        end
    endtask

    task automatic collect(input logic [14:0] thr_first, input int hold);
        logic [SIZE-1:0] et;
        et = model_table(thr_first);
        @(negedge clk);
        data_in_valid = 1'b0;
        chk("latency_valid", ind_valid, 1);
        chk("table", ind_table, et);
        chk("count", large_count, $countones(et));
        chk("mismatch", count_mismatch, ($countones(et) != NLC));
        chk("hold_ready", data_in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", ind_valid, 1);
            chk("bp_ready", data_in_ready, 0);
            chk("bp_table", ind_table, et);
        end
        ind_ready = 1'b1;
        @(negedge clk);
        ind_ready = 1'b0;
        chk("release_valid", ind_valid, 0);
        chk("release_ready", data_in_ready, 1);
    endtask

    task automatic run_tile(input logic [14:0] thr_first, input logic [14:0] thr_later,
                            input int gap_pct, input int hold);
        send_beats(DEPTH, thr_first, thr_later, gap_pct);
        collect(thr_first, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        data_in = '0;
        data_in_valid = 1'b0;
        threshold = '0;
        ind_ready = 1'b0;
        thr_r = 15'h4000;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", data_in_ready, 0);
        chk("rst_valid", ind_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_table", ind_table, 0);
        chk("rst_count", large_count, 0);
        chk("rst_mismatch", count_mismatch, 0);
        chk("idle_ready", data_in_ready, 1);

        // Basic tile
        fill(16'h3C00);
        cur[2][1] = 16'h4400;
        cur[0][3] = 16'hC500;
        run_tile(15'h4000, 15'h4000, 0, 0);
        chk("basic_table", ind_table, 4'b1010);
        chk("basic_count", large_count, 2);
        chk("basic_mismatch", count_mismatch, 0);

        // Equality, negative zero, NaN
        fill(16'h3C00);
        cur[1][0] = 16'h4000;
        cur[3][2] = 16'h8000;
        cur[2][1] = 16'h7E00;
        run_tile(15'h4000, 15'h4000, 0, 0);
        chk("eq_table", ind_table, 4'b0010);

        // Backpressure then back-to-back independent tile
        fill(16'h7C00);
        run_tile(15'h4000, 15'h4000, 0, 5);
        fill(16'h0000);
        cur[3][2] = 16'hC400;
        run_tile(15'h4000, 15'h4000, 0, 0);
        chk("b2b_table", ind_table, 4'b0100);

        // Threshold change after beat 0 with bubbles
        fill(16'h3400);
        cur[1][0] = 16'h3C00;
        cur[2][1] = 16'h4200;
        run_tile(15'h4000, 15'h3000, 60, 0);
        chk("thr_table", ind_table, 4'b0010);

        // Count mismatch
        fill(16'h4800);
        run_tile(15'h4000, 15'h4000, 0, 1);
        chk("mm_table", ind_table, 4'b1111);
        chk("mm_count", large_count, 4);
        chk("mm_flag", count_mismatch, 1);

        // Reset after beat 2 aborts the tile
        fill(16'h7C00);
        send_beats(3, 15'h0000, 15'h0000, 0);
        @(negedge clk);
        data_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", data_in_ready, 0);
        chk("abort_valid", ind_valid, 0);
        chk("abort_table", ind_table, 0);
        chk("abort_count", large_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle_valid", ind_valid, 0);
        fill(16'h3C00);
        cur[0][0] = 16'h4400;
        run_tile(15'h4000, 15'h4000, 0, 0);
        chk("post_abort_table", ind_table, 4'b0001);

        // Randomized tiles
        for (int t = 0; t < 30; t++) begin
            thr_r = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'h4000;
            for (int b = 0; b < DEPTH; b++)
                for (int c = 0; c < SIZE; c++)
                    cur[b][c] = rnd_elem();
            run_tile(thr_r, 15'($urandom), 30, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
